// File: rtl/mul_8x4_pkg.sv
// mul_8x4_pkg: shared widths and FSM state type for the shift-add multiply-accumulate block
package mul_8x4_pkg;
    localparam int W_MCAND = 8;
    localparam int W_MPLR  = 4;
    localparam int W_ADD   = 5;
    localparam int W_RES   = 12;
    localparam int CNT_W   = $clog2(W_MPLR);
    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_e;
endpackage

// File: rtl/add_12bit.sv
// add_12bit: combinational ripple adder computing a + (en ? b : 0)
// Ports: a, b - W-bit operands; en - gates b (multiplier bit); sum - W-bit sum, carry-out dropped
module add_12bit import mul_8x4_pkg::*; #(
    parameter int W = W_RES
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         en,
    output logic [W-1:0] sum
);
    logic [W-1:0] g;
    logic [W-1:0] c;
    assign g    = en ? b : '0;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < W; i++) begin : g_sum
        assign sum[i] = a[i] ^ g[i] ^ c[i];
    end
    // The final carry is never needed: the result range is bounded below 2**W.
    for (genvar i = 0; i < W - 1; i++) begin : g_carry
        assign c[i+1] = (a[i] & g[i]) | (c[i] & (a[i] ^ g[i]));
    end
endmodule

// File: rtl/mul_8x4_seq.sv
// mul_8x4_seq: sequential shift-add result = multiplicand * multiplier + addend, fixed W_MPLR iterations
// Ports: clk_i/rst_i - clock, async active-high reset
//        valid_i/ready_o, multiplicand_i, multiplier_i, addend_i - operand handshake
//        valid_o/ready_i, result_o, overflow_o - result handshake; overflow_o flags bits above W_MCAND
module mul_8x4_seq import mul_8x4_pkg::*; #(
    parameter int W_MCAND = mul_8x4_pkg::W_MCAND,
    parameter int W_MPLR  = mul_8x4_pkg::W_MPLR,
    parameter int W_ADD   = mul_8x4_pkg::W_ADD,
    parameter int W_RES   = mul_8x4_pkg::W_RES
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [W_MCAND-1:0] multiplicand_i,
    input  logic [W_MPLR-1:0]  multiplier_i,
    input  logic [W_ADD-1:0]   addend_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [W_RES-1:0]   result_o,
    output logic               overflow_o
);
    localparam int CW = $clog2(W_MPLR);
    mul_state_e        state;
    logic [W_RES-1:0]  acc;
    logic [W_RES-1:0]  mcand;
    logic [W_RES-1:0]  sum;
    logic [W_MPLR-1:0] mplr;
    logic [CW-1:0]     cnt;
    add_12bit #(.W(W_RES)) u_add (
        .a  (acc),
        .b  (mcand),
        .en (mplr[0]),
        .sum(sum)
    );
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (valid_i) begin
                    state <= RUN;
                    mcand <= W_RES'(multiplicand_i);
                    mplr  <= multiplier_i;
                    acc   <= W_RES'(addend_i);
                    cnt   <= '0;
                end
                // Always runs all W_MPLR steps so latency is independent of the operands.
                RUN: begin
                    acc   <= sum;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(W_MPLR - 1)) state <= DONE;
                end
                DONE: if (ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign ready_o    = (state == IDLE);
    assign valid_o    = (state == DONE);
    assign result_o   = acc;
    assign overflow_o = |acc[W_RES-1:W_MCAND];
endmodule

// File: doc/mul_8x4_seq.md
# mul_8x4_seq

Sequential shift-add multiply-accumulate block computing `result = multiplicand × multiplier + addend`. It is the inverse of the 8-bit by 4-bit restoring divider: from quotient, divisor and remainder it reconstructs the dividend. It sits beside the divider in the arithmetic datapath and also serves as the round-trip checker for that divider. The block uses valid/ready handshakes on both input and output, and has a fixed latency of four iterations.

## Interface
- `W_MCAND`, default 8: multiplicand (quotient) width.
- `W_MPLR`, default 4: multiplier (divisor) width; also the iteration count.
- `W_ADD`, default 5: addend (remainder) width.
- `W_RES`, default 12: result width; must be ≥ `W_MCAND`+`W_MPLR`.
- `clk_i` input, 1: clock, rising edge.
- `rst_i` input, 1: asynchronous, active-high reset.
- `valid_i` input, 1: operands valid.
- `ready_o` output, 1: block can accept operands.
- `multiplicand_i` input, `W_MCAND`: quotient.
- `multiplier_i` input, `W_MPLR`: divisor.
- `addend_i` input, `W_ADD`: remainder.
- `valid_o` output, 1: result valid.
- `ready_i` input, 1: downstream accepts result.
- `result_o` output, `W_RES`: multiplicand × multiplier + addend, unsigned.
- `overflow_o` output, 1: result does not fit in `W_MCAND` bits, i.e. `|result_o[W_RES-1:W_MCAND]`.

## Operation
- FSM states:
  - `IDLE`: `ready_o`=1.
  - `RUN`: iterating.
  - `DONE`: `valid_o`=1.
- `IDLE` → `RUN` on `valid_i & ready_o`. At that edge:
  - Latch `mcand` = zero-extended `multiplicand_i`.
  - Latch `mplr` = `multiplier_i`.
  - `acc` = zero-extended `addend_i`.
  - `cnt` = 0.
- Each `RUN` cycle:
  - If `mplr[0]`, then `acc` += `mcand`.
  - `mcand` <<= 1.
  - `mplr` >>= 1.
  - `cnt` += 1.
- `RUN` → `DONE` on the edge where `cnt` = `W_MPLR`-1. There is no early exit, including for multiplier=0.
- `DONE` → `IDLE` on `ready_i`. `result_o` and `overflow_o` hold stable while `valid_o` is high and `ready_i` is low.
- Arithmetic is unsigned and ceases to wrap inside `W_RES`. The maximum value is 255×15+31 = 3856 < 4096.
- `valid_i` is ignored outside `IDLE`. Operand inputs are don't-care after the accept edge.
- `ready_o` and `valid_o` are pure state decodes and are mutually exclusive. `ready_o`=0 during `RUN`.
- Reset at any time, including mid-`RUN` or in `DONE`, returns to `IDLE` immediately:
  - The in-flight operation is discarded.
  - No `valid_o` pulse is produced for it.

## Timing
- Reset values:
  - `ready_o`=1
  - `valid_o`=0
  - `result_o`=0
  - `overflow_o`=0
  - internal `acc`, `mcand`, `mplr`, `cnt` = 0
- Accept at edge N. `RUN` covers edges N+1 to N+4. `valid_o` rises after edge N+4.
- Latency is 4 cycles from accept to `valid_o`.
- With `ready_i` high in `DONE`:
  - `ready_o` rises after edge N+5.
  - The next accept can occur at edge N+5+1.
  - Minimum initiation interval is 6 cycles.
- `result_o` is driven from the `acc` register and holds its last value in `IDLE`. Consumers use it only while `valid_o`=1.
- `overflow_o` is registered with `acc` and is valid together with `valid_o`.

## Structure
- Package `mul_8x4_pkg` contains:
  - State enum `mul_state_e` {`IDLE`, `RUN`, `DONE`}.
  - Width constants `W_MCAND`, `W_MPLR`, `W_ADD`, `W_RES`.
  - `CNT_W` = `$clog2(W_MPLR)`.
- Sub-module `add_12bit`: combinational `W_RES`-bit ripple adder, `acc` + gated `mcand`. It is the counterpart of the divider's `csm_5bit` subtractor cells.
- The top level holds the FSM, the operand shift registers and the accumulator register.

## Test plan
- Basic case: multiplicand 0x11, multiplier 0x7, addend 0x03 → `result_o`=0x07A, `overflow_o`=0. `valid_o` rises exactly 4 cycles after accept.
- Maximum case: 0xFF, 0xF, 0x0E → 0xEFF, `overflow_o`=1. Then 0x0A, 0x3, 0x02 → 0x020, `overflow_o`=0.
- Zero multiplier: 0xAB, 0x0, 0x05 → 0x005 after the full 4-cycle latency.
- Back-pressure: hold `ready_i`=0 for 3 cycles in `DONE`.
  - `result_o` is stable and `ready_o`=0.
  - `valid_i` pulses are ignored.
  - The result is released on the `ready_i` edge, and `ready_o` is 1 the next cycle.
- Reset mid-`RUN`: assert `rst_i` 2 cycles after accept.
  - All outputs go to reset values asynchronously.
  - No `valid_o` appears.
  - A new operation accepted after reset computes correctly.
- Divider round-trip: for all 256×15 dividend/divisor pairs with divisor ≠ 0, feed divider quotient/remainder/divisor → `result_o` equals the dividend and `overflow_o`=0.
